fb_rect_filler: RTL and testbench
=================================

FB_RECT_FILLER -- requirements
Module: fb_rect_filler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clk and Reset, with all state updated on posedge Clk.
REQ-002 Parameter FB_WIDTH, default 480: framebuffer pixels per row.
REQ-003 Parameter FB_HEIGHT, default 360: framebuffer rows; FB_WIDTH*FB_HEIGHT = 172800 words.
REQ-004 Port Clk, input, 1: system clock.
REQ-005 Port Reset, input, 1: synchronous active-high reset.
REQ-006 Port cmd_valid, input, 1: rectangle command present.
REQ-007 Port cmd_ready, output, 1: block accepts a command this cycle.
REQ-008 Port cmd_x, input, 10: left column.
REQ-009 Port cmd_y, input, 10: top row.
REQ-010 Port cmd_w, input, 10: width in pixels.
REQ-011 Port cmd_h, input, 10: height in pixels.
REQ-012 Port cmd_color, input, 8: encoded colour, same encoding as the frame controller reads.
REQ-013 Port fb_we, output, 1: framebuffer write request.
REQ-014 Port fb_addr, output, 18: linear write address, y*FB_WIDTH + x.
REQ-015 Port fb_wdata, output, 8: pixel data to write.
REQ-016 Port fb_grant, input, 1: the write is accepted this cycle when fb_we and fb_grant are both high.
REQ-017 Port busy, output, 1: high in any state other than IDLE.
REQ-018 Port done, output, 1: one-cycle pulse when a command completes.

Function
REQ-019 The block SHALL have states IDLE, SETUP, FILL and DONE.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle with cmd_valid && cmd_ready, which latches all cmd_* fields and moves to SETUP.
REQ-021 In SETUP (exactly one cycle), the block SHALL compute x_end = min(x+w, FB_WIDTH) and y_end = min(y+h, FB_HEIGHT) using 11-bit sums so there is no wrap.
REQ-022 From SETUP, if x >= FB_WIDTH, y >= FB_HEIGHT, w == 0 or h == 0, the block SHALL go to DONE with no write; otherwise it SHALL load row_base = y*FB_WIDTH, cx = x, cy = y, fb_addr = row_base + x, and go to FILL.
REQ-023 In FILL, fb_we SHALL be 1 and fb_wdata SHALL equal the latched colour; with fb_grant low, fb_addr, fb_wdata and the counters SHALL hold unchanged.
REQ-024 In FILL with fb_grant high and cx < x_end-1, the block SHALL increment cx and fb_addr by 1.
REQ-025 In FILL with fb_grant high and cx == x_end-1 and cy < y_end-1, the block SHALL increment cy, add FB_WIDTH to row_base, set cx = x and set fb_addr = new row_base + x.
REQ-026 In FILL with fb_grant high at cx == x_end-1 and cy == y_end-1, the block SHALL go to DONE; fb_we SHALL be 0 from the next cycle.
REQ-027 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-028 The first fb_we SHALL occur 2 cycles after the accept edge; with fb_grant held high, exactly (x_end-x)*(y_end-y) writes SHALL occur on consecutive cycles.
REQ-029 Each pixel SHALL be written exactly once, in raster order, with no skipped or duplicated addresses under any fb_grant pattern.
REQ-030 fb_addr SHALL never reach or exceed FB_WIDTH*FB_HEIGHT while fb_we is 1.
REQ-031 cmd_valid while busy SHALL be ignored and SHALL NOT alter the latched command.

Reset
REQ-032 With Reset high at a clock edge, the block SHALL enter IDLE and drive fb_we=0, done=0, busy=0, fb_addr=0, fb_wdata=0 and cmd_ready=0.
REQ-033 cmd_ready SHALL go to 1 on the first edge after Reset is deasserted.
REQ-034 Reset asserted during SETUP or FILL SHALL abandon the command with no further writes, and SHALL NOT produce a done pulse.

Verification
REQ-035 x=0, y=0, w=2, h=2, color=0x1F, grant=1 -> fb_addr 0, 1, 480, 481 with data 0x1F on consecutive cycles starting at accept+2; done on the cycle after the last write.
REQ-036 x=478, y=359, w=5, h=4 -> exactly two writes, at 172798 and 172799; then done.
REQ-037 w=0 (x=10, y=10, h=5) -> no fb_we; done pulse 2 cycles after accept.
REQ-038 x=480, y=0, w=4, h=4 -> no fb_we; done.
REQ-039 x=5, y=1, w=3, h=1, with grant low for 3 cycles after the first write -> fb_addr holds at 486 during the stall; total writes are 485, 486, 487, each once.
REQ-040 Reset pulsed during FILL of a 10x10 fill -> fb_we=0 and busy=0 after the edge, no done pulse, cmd_ready=1 one cycle after Reset falls; a new command then executes normally.

Source files
------------

// File: rtl/fb_rect_filler.sv
// ============================================================================
// Module  : fb_rect_filler
// Purpose : Fills an axis-aligned rectangle of a linear 8-bit framebuffer with
//           a single colour, one pixel per granted write, in raster order.
//           The rectangle is clipped to the framebuffer edges; empty or fully
//           off-screen rectangles complete without writing anything.
// Ports   : Clk, Reset          - clock, synchronous active-high reset
//           cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//           cmd_x/y/w/h         - rectangle origin and size in pixels
//           cmd_color           - pixel value to write
//           fb_we/addr/wdata    - write request, address y*FB_WIDTH+x, data
//           fb_grant            - write accepted when fb_we && fb_grant
//           busy                - high whenever not IDLE
//           done                - one-cycle pulse when a command completes
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_rect_filler #(
  parameter int FB_WIDTH  = 480,
  parameter int FB_HEIGHT = 360
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  output logic        fb_we,
  output logic [17:0] fb_addr,
  output logic [7:0]  fb_wdata,
  input  logic        fb_grant,
  output logic        busy,
  output logic        done
);

  localparam logic [10:0] C_W11 = 11'(FB_WIDTH);
  localparam logic [10:0] C_H11 = 11'(FB_HEIGHT);
  localparam logic [17:0] C_W18 = 18'(FB_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Holds cmd_ready low for the cycle following a reset edge so that ready
  // first rises on the edge after Reset is released.
  logic        post_reset;

  logic [9:0]  x_q, y_q, w_q, h_q;
  logic [10:0] x_end, y_end;
  logic [9:0]  cx, cy;
  logic [17:0] row_base;

  logic [10:0] sum_x, sum_y, x_end_calc, y_end_calc;
  logic [17:0] row_base_calc;
  logic        empty, accept, row_end, last_row;

  // 11-bit sums cannot wrap for 10-bit operands, so clipping is a plain min.
  always_comb begin
    sum_x         = {1'b0, x_q} + {1'b0, w_q};
    sum_y         = {1'b0, y_q} + {1'b0, h_q};
    x_end_calc    = (sum_x > C_W11) ? C_W11 : sum_x;
    y_end_calc    = (sum_y > C_H11) ? C_H11 : sum_y;
    row_base_calc = {8'd0, y_q} * C_W18;
    empty         = ({1'b0, x_q} >= C_W11) || ({1'b0, y_q} >= C_H11) ||
                    (w_q == 10'd0) || (h_q == 10'd0);
    row_end       = ({1'b0, cx} == (x_end - 11'd1));
    last_row      = ({1'b0, cy} == (y_end - 11'd1));
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      post_reset <= 1'b1;
    end else begin
      state      <= state_next;
      post_reset <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    fb_we      = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    accept     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !post_reset;
        accept    = cmd_valid && !post_reset;
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        state_next = empty ? DONE : FILL;
      end
      FILL: begin
        fb_we = 1'b1;
        if (fb_grant && row_end && last_row) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: command latch, clipped bounds, raster counters and address
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      x_end    <= '0;
      y_end    <= '0;
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_q      <= cmd_x;
            y_q      <= cmd_y;
            w_q      <= cmd_w;
            h_q      <= cmd_h;
            fb_wdata <= cmd_color;
          end
        end
        SETUP: begin
          x_end <= x_end_calc;
          y_end <= y_end_calc;
          if (!empty) begin
            row_base <= row_base_calc;
            cx       <= x_q;
            cy       <= y_q;
            fb_addr  <= row_base_calc + {8'd0, x_q};
          end
        end
        FILL: begin
          if (fb_grant) begin
            if (!row_end) begin
              cx      <= cx + 10'd1;
              fb_addr <= fb_addr + 18'd1;
            end else if (!last_row) begin
              cy       <= cy + 10'd1;
              cx       <= x_q;
              row_base <= row_base + C_W18;
              fb_addr  <= row_base + C_W18 + {8'd0, x_q};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_rect_filler.sv
// ============================================================================
// Module  : tb_fb_rect_filler
// Purpose : Directed self-checking bench for fb_rect_filler (480x360).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_rect_filler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [7:0]  cmd_color;
  logic        fb_we;
  logic [17:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_grant;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] stall_addr[$];
  int          first_we;
  int          done_at;
  int          oob;

  fb_rect_filler #(.FB_WIDTH(480), .FB_HEIGHT(360)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_grant  (fb_grant),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a command and return 1 ns after the accept edge (SETUP cycle).
  task automatic send(input string tag, input int x, input int y, input int w,
                      input int h, input int c);
    int guard = 0;
    while (!cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_x     = 10'(x);
    cmd_y     = 10'(y);
    cmd_w     = 10'(w);
    cmd_h     = 10'(h);
    cmd_color = 8'(c);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Cycle k=1 is the cycle after the accept edge. Grant is low for
  // k in [stall_lo, stall_hi]. Stops when done is seen (bounded).
  task automatic collect(input int stall_lo, input int stall_hi);
    wr_addr.delete();
    wr_data.delete();
    stall_addr.delete();
    first_we = -1;
    done_at  = -1;
    oob      = 0;
    for (int k = 1; k <= 200; k++) begin
      fb_grant = !(k >= stall_lo && k <= stall_hi);
      if (fb_we && first_we < 0) first_we = k;
      if (fb_we && fb_addr >= 18'd172800) oob++;
      if (fb_we && fb_grant) begin
        wr_addr.push_back(32'(fb_addr));
        wr_data.push_back(32'(fb_wdata));
      end else if (fb_we) begin
        stall_addr.push_back(32'(fb_addr));
      end
      if (done) begin
        done_at = k;
        break;
      end
      tick();
    end
    fb_grant = 1'b1;
  endtask

  initial begin
    Reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    fb_grant  = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_we",    32'(fb_we),     32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_addr",  32'(fb_addr),   32'd0);
    chk("rst_wdata", 32'(fb_wdata),  32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    Reset = 1'b0;
    tick();
    chk("rst_ready_rise", 32'(cmd_ready), 32'd1);

    // 2x2 at origin, cycle by cycle
    send("t1", 0, 0, 2, 2, 8'h1F);
    chk("t1_setup_we",    32'(fb_we),     32'd0);
    chk("t1_setup_busy",  32'(busy),      32'd1);
    chk("t1_setup_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("t1_we0",   32'(fb_we),    32'd1);
    chk("t1_a0",    32'(fb_addr),  32'd0);
    chk("t1_d0",    32'(fb_wdata), 32'h1F);
    tick();
    chk("t1_a1",    32'(fb_addr),  32'd1);
    tick();
    chk("t1_a2",    32'(fb_addr),  32'd480);
    tick();
    chk("t1_a3",    32'(fb_addr),  32'd481);
    chk("t1_we3",   32'(fb_we),    32'd1);
    tick();
    chk("t1_done",  32'(done),     32'd1);
    chk("t1_we_off",32'(fb_we),    32'd0);
    tick();
    chk("t1_done_off", 32'(done),      32'd0);
    chk("t1_idle_busy",32'(busy),      32'd0);
    chk("t1_idle_rdy", 32'(cmd_ready), 32'd1);

    // Bottom-right corner clipping, with a stray command held during busy
    send("t2", 478, 359, 5, 4, 8'h77);
    cmd_x     = 10'd0;
    cmd_y     = 10'd0;
    cmd_w     = 10'd9;
    cmd_h     = 10'd9;
    cmd_color = 8'h00;
    cmd_valid = 1'b1;
    collect(0, -1);
    cmd_valid = 1'b0;
    chk("t2_n",     32'(wr_addr.size()), 32'd2);
    chk("t2_a0",    wr_addr[0], 32'd172798);
    chk("t2_a1",    wr_addr[1], 32'd172799);
    chk("t2_d1",    wr_data[1], 32'h77);
    chk("t2_first", 32'(first_we), 32'd2);
    chk("t2_done",  32'(done_at),  32'd4);
    chk("t2_oob",   32'(oob),      32'd0);
    tick();

    // Zero width
    send("t3", 10, 10, 0, 5, 8'h12);
    collect(0, -1);
    chk("t3_nowe", 32'(first_we), 32'hFFFF_FFFF);
    chk("t3_done", 32'(done_at),  32'd2);
    tick();

    // Origin off the right edge
    send("t4", 480, 0, 4, 4, 8'h34);
    collect(0, -1);
    chk("t4_nowe", 32'(first_we), 32'hFFFF_FFFF);
    chk("t4_done", 32'(done_at),  32'd2);
    tick();

    // Grant stall after the first write
    send("t5", 5, 1, 3, 1, 8'hA5);
    collect(3, 5);
    chk("t5_n",      32'(wr_addr.size()),    32'd3);
    chk("t5_a0",     wr_addr[0], 32'd485);
    chk("t5_a1",     wr_addr[1], 32'd486);
    chk("t5_a2",     wr_addr[2], 32'd487);
    chk("t5_d0",     wr_data[0], 32'hA5);
    chk("t5_stalln", 32'(stall_addr.size()), 32'd3);
    chk("t5_s0",     stall_addr[0], 32'd486);
    chk("t5_s2",     stall_addr[2], 32'd486);
    chk("t5_done",   32'(done_at), 32'd8);
    tick();

    // Reset during FILL of a 10x10 rectangle
    send("t6", 20, 5, 10, 10, 8'h55);
    tick();
    chk("t6_a0", 32'(fb_addr), 32'd2420);
    tick();
    tick();
    chk("t6_a2", 32'(fb_addr), 32'd2422);
    Reset = 1'b1;
    tick();
    chk("t6_rst_we",    32'(fb_we),     32'd0);
    chk("t6_rst_busy",  32'(busy),      32'd0);
    chk("t6_rst_done",  32'(done),      32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd0);
    Reset = 1'b0;
    tick();
    chk("t6_ready",     32'(cmd_ready), 32'd1);
    chk("t6_nodone",    32'(done),      32'd0);
    chk("t6_idle_we",   32'(fb_we),     32'd0);

    // Fresh command after the abandoned one
    send("t7", 1, 2, 2, 1, 8'h3C);
    collect(0, -1);
    chk("t7_n",     32'(wr_addr.size()), 32'd2);
    chk("t7_a0",    wr_addr[0], 32'd961);
    chk("t7_a1",    wr_addr[1], 32'd962);
    chk("t7_d0",    wr_data[0], 32'h3C);
    chk("t7_first", 32'(first_we), 32'd2);
    chk("t7_done",  32'(done_at),  32'd4);
    tick();
    chk("t7_idle",  32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
